// File: rtl/fuel_order_entry.sv
// Pump keypad order entry: grade select, 6-digit BCD amount, lock until dispense is done.
// All outputs registered, one cycle after the key edge; no backpressure, keys are single-cycle strobes.
module fuel_order_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        dispense_done,
  output logic [23:0] keyboard,
  output logic [2:0]  select,
  output logic        start,
  output logic [2:0]  digit_cnt,
  output logic        err,
  output logic [1:0]  state
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_AMOUNT = 2'b01;
  localparam logic [1:0] S_LOCKED = 2'b10;

  localparam logic [3:0] K_BKSP  = 4'hD;
  localparam logic [3:0] K_CLEAR = 4'hE;
  localparam logic [3:0] K_ENTER = 4'hF;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  // to_phase halves the count rate: to_cnt advances on every second idle cycle
  logic [CW-1:0] to_cnt;
  logic          to_phase;

  logic       is_digit;
  logic       is_grade;
  logic [2:0] grade_sel;

  always_comb begin
    is_digit  = (key_code <= 4'd9);
    is_grade  = (key_code == 4'hA) || (key_code == 4'hB) || (key_code == 4'hC);
    grade_sel = 3'b000;
    case (key_code)
      4'hA:    grade_sel = 3'b001;
      4'hB:    grade_sel = 3'b010;
      4'hC:    grade_sel = 3'b100;
      default: grade_sel = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      keyboard  <= 24'h0;
      select    <= 3'b000;
      start     <= 1'b0;
      digit_cnt <= 3'd0;
      err       <= 1'b0;
      to_cnt    <= '0;
      to_phase  <= 1'b0;
    end else begin
      err      <= 1'b0;
      to_cnt   <= '0;
      to_phase <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_valid) begin
            if (is_grade) begin
              select    <= grade_sel;
              keyboard  <= 24'h0;
              digit_cnt <= 3'd0;
              state     <= S_AMOUNT;
            end else if (key_code != K_CLEAR) begin
              err <= 1'b1;
            end
          end
        end

        S_AMOUNT: begin
          if (key_valid) begin
            // a key of any kind restarts the abandon timer (cleared by the defaults above)
            if (is_digit) begin
              if (key_code == 4'd0 && digit_cnt == 3'd0) begin
                // leading zero: silently dropped
              end else if (digit_cnt == 3'd6) begin
                err <= 1'b1;
              end else begin
                keyboard  <= {keyboard[19:0], key_code};
                digit_cnt <= digit_cnt + 3'd1;
              end
            end else if (is_grade) begin
              select <= grade_sel;
            end else if (key_code == K_BKSP) begin
              if (digit_cnt == 3'd0) begin
                err <= 1'b1;
              end else begin
                keyboard  <= {4'h0, keyboard[23:4]};
                digit_cnt <= digit_cnt - 3'd1;
              end
            end else if (key_code == K_CLEAR) begin
              keyboard  <= 24'h0;
              select    <= 3'b000;
              digit_cnt <= 3'd0;
              state     <= S_IDLE;
            end else begin
              if (digit_cnt == 3'd0) begin
                err <= 1'b1;
              end else begin
                start <= 1'b1;
                state <= S_LOCKED;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            keyboard  <= 24'h0;
            select    <= 3'b000;
            digit_cnt <= 3'd0;
            state     <= S_IDLE;
          end else begin
            to_phase <= ~to_phase;
            to_cnt   <= to_phase ? to_cnt + 1'b1 : to_cnt;
          end
        end

        S_LOCKED: begin
          // completion wins over a coincident key, which is dropped without err
          if (dispense_done) begin
            keyboard  <= 24'h0;
            select    <= 3'b000;
            digit_cnt <= 3'd0;
            start     <= 1'b0;
            state     <= S_IDLE;
          end else if (key_valid) begin
            err <= 1'b1;
          end
        end

        default: begin
          keyboard  <= 24'h0;
          select    <= 3'b000;
          digit_cnt <= 3'd0;
          start     <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fuel_order_entry.sv
// Directed vector bench for fuel_order_entry: table of key steps plus timeout sequences.
module tb_fuel_order_entry;

  localparam int TO = 8;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] A = 2'b01;
  localparam logic [1:0] L = 2'b10;
  localparam logic [2:0] S92 = 3'b001;
  localparam logic [2:0] S95 = 3'b010;
  localparam logic [2:0] SD  = 3'b100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        dispense_done = 1'b0;
  logic [23:0] keyboard;
  logic [2:0]  select;
  logic        start;
  logic [2:0]  digit_cnt;
  logic        err;
  logic [1:0]  state;

  int total = 0;
  int bad = 0;

  fuel_order_entry #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .dispense_done(dispense_done), .keyboard(keyboard), .select(select),
    .start(start), .digit_cnt(digit_cnt), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        kv;
    logic [3:0]  kc;
    logic        dd;
    logic [23:0] kb;
    logic [2:0]  sel;
    logic        st;
    logic [2:0]  cnt;
    logic        er;
    logic [1:0]  fsm;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic kv, input logic [3:0] kc, input logic dd,
                              input logic [23:0] kb, input logic [2:0] sel, input logic st,
                              input logic [2:0] cnt, input logic er, input logic [1:0] fsm);
    vec_t v;
    v.rst_n = rst_n; v.kv = kv; v.kc = kc; v.dd = dd;
    v.kb = kb; v.sel = sel; v.st = st; v.cnt = cnt; v.er = er; v.fsm = fsm;
    return v;
  endfunction

  function automatic vec_t k(input logic [3:0] kc, input logic [23:0] kb, input logic [2:0] sel,
                             input logic st, input logic [2:0] cnt, input logic er, input logic [1:0] fsm);
    return mk(1'b1, 1'b1, kc, 1'b0, kb, sel, st, cnt, er, fsm);
  endfunction

  function automatic vec_t idle(input logic [23:0] kb, input logic [2:0] sel, input logic st,
                                input logic [2:0] cnt, input logic er, input logic [1:0] fsm);
    return mk(1'b1, 1'b0, 4'h0, 1'b0, kb, sel, st, cnt, er, fsm);
  endfunction

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst_n; key_valid = v.kv; key_code = v.kc; dispense_done = v.dd;
    @(posedge clk);
    #1;
    total++;
    if ({keyboard, select, start, digit_cnt, err, state} !==
        {v.kb, v.sel, v.st, v.cnt, v.er, v.fsm}) begin
      bad++;
      $display("FAIL %s: got kb=%h sel=%b start=%b cnt=%0d err=%b state=%b, want kb=%h sel=%b start=%b cnt=%0d err=%b state=%b",
               nm, keyboard, select, start, digit_cnt, err, state,
               v.kb, v.sel, v.st, v.cnt, v.er, v.fsm);
    end
  endtask

  // idle steps that must leave the AMOUNT entry untouched
  task automatic hold_idle(input int n, input logic [23:0] kb, input logic [2:0] sel,
                           input logic [2:0] cnt, input string nm);
    for (int i = 0; i < n; i++)
      apply(idle(kb, sel, 1'b0, cnt, 1'b0, A), $sformatf("%s_hold%0d", nm, i));
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    // B,1,2,5,0,0,0,F then dispense
    tbl.push_back(k(4'hB, 24'h0,      S95, 1'b0, 3'd0, 1'b0, A));
    tbl.push_back(k(4'h1, 24'h1,      S95, 1'b0, 3'd1, 1'b0, A));
    tbl.push_back(k(4'h2, 24'h12,     S95, 1'b0, 3'd2, 1'b0, A));
    tbl.push_back(k(4'h5, 24'h125,    S95, 1'b0, 3'd3, 1'b0, A));
    tbl.push_back(k(4'h0, 24'h1250,   S95, 1'b0, 3'd4, 1'b0, A));
    tbl.push_back(k(4'h0, 24'h12500,  S95, 1'b0, 3'd5, 1'b0, A));
    tbl.push_back(k(4'h0, 24'h125000, S95, 1'b0, 3'd6, 1'b0, A));
    tbl.push_back(k(4'hF, 24'h125000, S95, 1'b1, 3'd6, 1'b0, L));
    tbl.push_back(idle(24'h125000, S95, 1'b1, 3'd6, 1'b0, L));
    tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    // A,0,7,7,D,3,F
    tbl.push_back(k(4'hA, 24'h0,  S92, 1'b0, 3'd0, 1'b0, A));
    tbl.push_back(k(4'h0, 24'h0,  S92, 1'b0, 3'd0, 1'b0, A));
    tbl.push_back(k(4'h7, 24'h7,  S92, 1'b0, 3'd1, 1'b0, A));
    tbl.push_back(k(4'h7, 24'h77, S92, 1'b0, 3'd2, 1'b0, A));
    tbl.push_back(k(4'hD, 24'h7,  S92, 1'b0, 3'd1, 1'b0, A));
    tbl.push_back(k(4'h3, 24'h73, S92, 1'b0, 3'd2, 1'b0, A));
    tbl.push_back(k(4'hF, 24'h73, S92, 1'b1, 3'd2, 1'b0, L));
    tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    // IDLE: digit/F rejected, E accepted, stray dispense_done ignored
    tbl.push_back(k(4'h5, 24'h0, 3'b0, 1'b0, 3'd0, 1'b1, I));
    tbl.push_back(k(4'hE, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    tbl.push_back(k(4'hF, 24'h0, 3'b0, 1'b0, 3'd0, 1'b1, I));
    // C,1..6 then 7 overflows
    tbl.push_back(k(4'hC, 24'h0,      SD, 1'b0, 3'd0, 1'b0, A));
    tbl.push_back(k(4'h1, 24'h1,      SD, 1'b0, 3'd1, 1'b0, A));
    tbl.push_back(k(4'h2, 24'h12,     SD, 1'b0, 3'd2, 1'b0, A));
    tbl.push_back(k(4'h3, 24'h123,    SD, 1'b0, 3'd3, 1'b0, A));
    tbl.push_back(k(4'h4, 24'h1234,   SD, 1'b0, 3'd4, 1'b0, A));
    tbl.push_back(k(4'h5, 24'h12345,  SD, 1'b0, 3'd5, 1'b0, A));
    tbl.push_back(k(4'h6, 24'h123456, SD, 1'b0, 3'd6, 1'b0, A));
    tbl.push_back(k(4'h7, 24'h123456, SD, 1'b0, 3'd6, 1'b1, A));
    tbl.push_back(idle(24'h123456, SD, 1'b0, 3'd6, 1'b0, A));
    tbl.push_back(k(4'hF, 24'h123456, SD, 1'b1, 3'd6, 1'b0, L));
    tbl.push_back(k(4'h9, 24'h123456, SD, 1'b1, 3'd6, 1'b1, L));
    tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    // amount 50, grade swap keeps amount, locked key rejected, key+done drops key
    tbl.push_back(k(4'hA, 24'h0,  S92, 1'b0, 3'd0, 1'b0, A));
    tbl.push_back(k(4'h5, 24'h5,  S92, 1'b0, 3'd1, 1'b0, A));
    tbl.push_back(k(4'h0, 24'h50, S92, 1'b0, 3'd2, 1'b0, A));
    tbl.push_back(k(4'hB, 24'h50, S95, 1'b0, 3'd2, 1'b0, A));
    tbl.push_back(k(4'hF, 24'h50, S95, 1'b1, 3'd2, 1'b0, L));
    tbl.push_back(k(4'h9, 24'h50, S95, 1'b1, 3'd2, 1'b1, L));
    tbl.push_back(mk(1'b1, 1'b1, 4'h9, 1'b1, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    // empty backspace / enter rejected, clear returns to IDLE
    tbl.push_back(k(4'hC, 24'h0, SD,   1'b0, 3'd0, 1'b0, A));
    tbl.push_back(k(4'hD, 24'h0, SD,   1'b0, 3'd0, 1'b1, A));
    tbl.push_back(k(4'hF, 24'h0, SD,   1'b0, 3'd0, 1'b1, A));
    tbl.push_back(k(4'h4, 24'h4, SD,   1'b0, 3'd1, 1'b0, A));
    tbl.push_back(k(4'hE, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    // reset in LOCKED beats a coincident key; first edge after reset accepts a key
    tbl.push_back(k(4'hA, 24'h0, S92, 1'b0, 3'd0, 1'b0, A));
    tbl.push_back(k(4'h8, 24'h8, S92, 1'b0, 3'd1, 1'b0, A));
    tbl.push_back(k(4'hF, 24'h8, S92, 1'b1, 3'd1, 1'b0, L));
    tbl.push_back(mk(1'b0, 1'b1, 4'h9, 1'b0, 24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I));
    tbl.push_back(k(4'hA, 24'h0, S92, 1'b0, 3'd0, 1'b0, A));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout: counter advances every second idle cycle, so it hits TO-1
    // after 2*TO-2 idle edges and the following edge abandons the order.
    apply(k(4'hF, 24'h0, S92, 1'b0, 3'd0, 1'b1, A), "to_enter_empty");
    apply(k(4'h5, 24'h5, S92, 1'b0, 3'd1, 1'b0, A), "to_digit5");
    hold_idle(10, 24'h5, S92, 3'd1, "to_a");
    apply(k(4'h6, 24'h56, S92, 1'b0, 3'd2, 1'b0, A), "to_restart_key");
    hold_idle(2 * TO - 2, 24'h56, S92, 3'd2, "to_b");
    // key on the expiry edge wins over the timeout
    apply(k(4'h7, 24'h567, S92, 1'b0, 3'd3, 1'b0, A), "to_key_priority");
    hold_idle(2 * TO - 2, 24'h567, S92, 3'd3, "to_c");
    apply(idle(24'h0, 3'b0, 1'b0, 3'd0, 1'b0, I), "to_expire");
    apply(k(4'h3, 24'h0, 3'b0, 1'b0, 3'd0, 1'b1, I), "to_after_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
